// File: rtl/servo_sequencer.sv
// Four-channel servo pulse sequencer: each channel gets one slot per frame.
// Positions slew toward written targets once per frame, on the frame's last cycle.
module servo_sequencer #(
  parameter int unsigned SLOT_TICKS = 50000,
  parameter int unsigned MIN_TICKS  = 10000,
  parameter int unsigned STEP_TICKS = 40,
  parameter int unsigned SLEW_STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_chan,
  input  logic [7:0] cfg_pos,
  output logic [3:0] pwm_out,
  output logic [1:0] active_chan,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned TW = ($clog2(SLOT_TICKS) > 18) ? $clog2(SLOT_TICKS) : 18;
  localparam logic [TW-1:0] LAST_TICK = TW'(SLOT_TICKS - 1);
  localparam logic [8:0]    SLEW9     = 9'(SLEW_STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_slot, w_slot_nx;
  logic [TW-1:0] r_tick, w_tick_nx;
  logic [TW-1:0] r_width, w_width_nx;
  logic [7:0]    r_tgt [4];
  logic [7:0]    r_cur [4];
  logic [7:0]    w_cur_nx [4];
  logic [3:0]    r_pwm, w_pwm_nx;
  logic          r_fs, w_fs_nx;
  logic          r_ready;
  logic          w_slew, w_slew_nx, w_wr;

  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] d;
    if (tgt >= cur) begin
      d = {1'b0, tgt} - {1'b0, cur};
      slew_toward = (d > SLEW9) ? 8'({1'b0, cur} + SLEW9) : tgt;
    end else begin
      d = {1'b0, cur} - {1'b0, tgt};
      slew_toward = (d > SLEW9) ? 8'({1'b0, cur} - SLEW9) : tgt;
    end
  endfunction

  always_comb begin
    w_slew     = (r_state == RUN) && (r_slot == 2'd3) && (r_tick == LAST_TICK);
    w_wr       = cfg_valid && r_ready;
    w_state_nx = r_state;
    w_slot_nx  = r_slot;
    w_tick_nx  = r_tick;
    if (r_state == IDLE) begin
      if (enable) begin
        w_state_nx = RUN;
        w_slot_nx  = '0;
        w_tick_nx  = '0;
      end
    end else begin
      if (!enable) begin
        w_state_nx = IDLE;
        w_slot_nx  = '0;
        w_tick_nx  = '0;
      end else if (r_tick == LAST_TICK) begin
        w_tick_nx = '0;
        w_slot_nx = r_slot + 2'd1;
      end else begin
        w_tick_nx = r_tick + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      w_cur_nx[c] = w_slew ? slew_toward(r_cur[c], r_tgt[c]) : r_cur[c];
    end
  end

  // Outputs are registered from next-cycle counters so pwm_out aligns with slot/tick.
  always_comb begin
    w_width_nx = r_width;
    if ((w_state_nx == RUN) && (w_tick_nx == '0)) begin
      w_width_nx = TW'(MIN_TICKS + 32'(w_cur_nx[w_slot_nx]) * STEP_TICKS);
    end
    w_pwm_nx = '0;
    if ((w_state_nx == RUN) && (w_tick_nx < w_width_nx)) begin
      w_pwm_nx[w_slot_nx] = 1'b1;
    end
    w_fs_nx   = (w_state_nx == RUN) && (w_slot_nx == 2'd0) && (w_tick_nx == '0);
    w_slew_nx = (w_state_nx == RUN) && (w_slot_nx == 2'd3) && (w_tick_nx == LAST_TICK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_tick  <= '0;
      r_width <= '0;
      r_pwm   <= '0;
      r_fs    <= 1'b0;
      r_ready <= 1'b0;
      for (int unsigned c = 0; c < 4; c++) begin
        r_tgt[c] <= 8'd128;
        r_cur[c] <= 8'd128;
      end
    end else begin
      r_state <= w_state_nx;
      r_slot  <= w_slot_nx;
      r_tick  <= w_tick_nx;
      r_width <= w_width_nx;
      r_pwm   <= w_pwm_nx;
      r_fs    <= w_fs_nx;
      r_ready <= !w_slew_nx;
      for (int unsigned c = 0; c < 4; c++) begin
        r_cur[c] <= w_cur_nx[c];
      end
      if (w_wr) begin
        r_tgt[cfg_chan] <= cfg_pos;
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign active_chan = r_slot;
  assign frame_start = r_fs;
  assign busy        = (r_state == RUN);
  assign cfg_ready   = r_ready;

endmodule

// File: doc/servo_sequencer.md
SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 SHALL have parameter SLOT_TICKS, default 50000: clk cycles per channel slot; frame = 4*SLOT_TICKS.
REQ-002 SHALL have parameter MIN_TICKS, default 10000: pulse width at position 0.
REQ-003 SHALL have parameter STEP_TICKS, default 40: added pulse cycles per position unit.
REQ-004 SHALL have parameter SLEW_STEP, default 4: max position change per channel per frame, range 1..255.
REQ-005 SHALL have parameter constraint MIN_TICKS + 255*STEP_TICKS < SLOT_TICKS; no runtime check.
REQ-006 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port enable, input, 1: run frames while high.
REQ-009 SHALL have port cfg_valid, input, 1: target write request.
REQ-010 SHALL have port cfg_ready, output, 1: write accepted when cfg_valid && cfg_ready.
REQ-011 SHALL have port cfg_chan, input, 2: channel index of write.
REQ-012 SHALL have port cfg_pos, input, 8: target position 0..255.
REQ-013 SHALL have port pwm_out, output, 4: registered servo pulse per channel.
REQ-014 SHALL have port active_chan, output, 2: slot currently being served.
REQ-015 SHALL have port frame_start, output, 1: one-cycle pulse on the first cycle of each frame.
REQ-016 SHALL have port busy, output, 1: high when state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE and RUN, plus slot counter (2 bits) and tick counter (>=18 bits, wrapping at SLOT_TICKS-1).
REQ-018 SHALL transition IDLE->RUN when enable is sampled high; the first RUN cycle is slot 0, tick 0, with frame_start=1.
REQ-019 SHALL, in RUN, advance tick each cycle; at tick SLOT_TICKS-1, reset tick to 0 and increment slot, wrapping from 3 to 0.
REQ-020 SHALL latch width = MIN_TICKS + cur_pos[slot]*STEP_TICKS at tick 0 of each slot, using cur_pos as of that cycle.
REQ-021 SHALL drive pwm_out[slot]=1 for exactly width consecutive cycles starting at tick 0; all other pwm bits 0.
REQ-022 SHALL, on the last cycle of a frame (slot 3, tick SLOT_TICKS-1), move each cur_pos toward its target by min(SLEW_STEP, |target-cur_pos|), using 9-bit arithmetic; never overshoot or wrap.
REQ-023 SHALL hold cfg_ready=0 on that slew cycle and 1 in all other non-reset cycles, so write and slew never coincide.
REQ-024 SHALL update target[cfg_chan] to cfg_pos on an accepted write; it takes effect at the next slew.
REQ-025 SHALL, when enable is sampled low in RUN, force pwm_out to 0 in the next cycle, return to IDLE, and clear slot and tick.
REQ-026 SHALL retain targets and cur_pos across enable toggles; a restart begins at slot 0.
REQ-027 SHALL allow back-to-back writes on consecutive cycles; the last write to a channel before a slew wins.
REQ-028 SHALL hold active_chan = slot in RUN and 0 in IDLE; frame_start SHALL be 0 in IDLE.

Reset
REQ-029 SHALL, with reset high, set state IDLE, slot 0, tick 0, all pwm_out 0, frame_start 0, busy 0, cfg_ready 0.
REQ-030 SHALL, with reset high, set all target and cur_pos values to 128.
REQ-031 SHALL give reset priority over enable and writes; reset mid-pulse drops pwm_out to 0 on the next cycle.

Verification
REQ-032 SHALL be verified with SLOT_TICKS=400, MIN_TICKS=20, STEP_TICKS=1, SLEW_STEP=4 in all scenarios below.
REQ-033 SHALL verify: reset then enable=1 -> frame_start on first RUN cycle; pwm_out[0..3] each high 148 cycles at slot offsets 0/400/800/1200.
REQ-034 SHALL verify: write ch2=255 -> ch2 width 148, then 152, 156, ... per frame, reaching 275 after 32 frames and holding.
REQ-035 SHALL verify: write ch1=130 after cur_pos settles at 128 -> next frame width 150, no overshoot; write ch1=0 -> width decreases by 4 per frame to 20.
REQ-036 SHALL verify: cfg_valid held high across a frame boundary -> cfg_ready=0 only on the slot3/tick399 cycle, and the write is accepted the following cycle.
REQ-037 SHALL verify: enable=0 at slot 1 tick 50 -> pwm_out=0 and busy=0 next cycle; re-enable -> restart at slot 0 with retained positions.
REQ-038 SHALL verify: reset asserted mid-pulse of ch3 -> all outputs at reset values next cycle; positions back at 128.
